branch_sched: RTL and testbench

//  ID-stage branch scheduler for the 5-stage pipeline. Drives the branch comparator
//  (op select, enable, operand forwarding muxes) and stalls ID/IF on operand hazards.

---
 rtl/branch_sched_if.sv | 47 ++++
 rtl/branch_sched.sv | 150 +++++++++++++++
 tb/tb_branch_sched.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sched_if.sv
// Bundle of ID-stage, producer, comparator and statistics signals around the branch scheduler.
interface branch_sched_if #(
  parameter int unsigned CNT_W = 32
);
  logic             id_valid;
  logic             id_is_branch;
  logic [1:0]       id_cmp_op;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [31:0]      id_target;
  logic             ext_stall;
  logic             ex_wr_en;
  logic [4:0]       ex_wr_addr;
  logic             mem_wr_en;
  logic [4:0]       mem_wr_addr;
  logic             mem_is_load;
  logic             wb_wr_en;
  logic [4:0]       wb_wr_addr;
  logic             cmp_result;
  logic [1:0]       cmp_op;
  logic             cmp_b;
  logic [1:0]       fwd_rs_sel;
  logic [1:0]       fwd_rt_sel;
  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             err;
  logic [CNT_W-1:0] n_branch;
  logic [CNT_W-1:0] n_taken;
  logic [CNT_W-1:0] n_stall;

  modport slave (
    input  id_valid, id_is_branch, id_cmp_op, id_rs, id_rt, id_target, ext_stall,
           ex_wr_en, ex_wr_addr, mem_wr_en, mem_wr_addr, mem_is_load,
           wb_wr_en, wb_wr_addr, cmp_result,
    output cmp_op, cmp_b, fwd_rs_sel, fwd_rt_sel, stall, redirect, redirect_pc,
           err, n_branch, n_taken, n_stall
  );

  modport master (
    output id_valid, id_is_branch, id_cmp_op, id_rs, id_rt, id_target, ext_stall,
           ex_wr_en, ex_wr_addr, mem_wr_en, mem_wr_addr, mem_is_load,
           wb_wr_en, wb_wr_addr, cmp_result,
    input  cmp_op, cmp_b, fwd_rs_sel, fwd_rt_sel, stall, redirect, redirect_pc,
           err, n_branch, n_taken, n_stall
  );
endinterface

// File: rtl/branch_sched.sv
// ID-stage branch scheduler: hazard stall, operand forwarding, compare/redirect and statistics.
// Branches resolve in the same cycle the comparator sees them, so the control outputs are decoded.
module branch_sched #(
  parameter int unsigned MAX_STALL = 3,
  parameter int unsigned CNT_W     = 32
) (
  input  logic            clk,
  input  logic            reset,
  branch_sched_if.slave   bus
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state, state_d;
  logic [1:0]         op_q;
  logic [4:0]         rs_q, rt_q;
  logic [31:0]        tgt_q, rpc_q;
  logic [WAIT_W-1:0]  wait_cnt, wait_d;
  logic               err_q;
  logic [CNT_W-1:0]   n_branch_q, n_taken_q, n_stall_q;

  logic               go, hazard, haz_rs, haz_rt;
  logic               resolve, stall_c, enter, count;
  logic [1:0]         eff_op;
  logic [4:0]         eff_rs, eff_rt, rt_e;
  logic [31:0]        eff_tgt;
  logic [1:0]         fwd_rs, fwd_rt;

  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input logic m_en, input logic m_ld,
                                         input logic [4:0] m_a,
                                         input logic w_en, input logic [4:0] w_a);
    if (r == 5'd0)                      return 2'd0;
    else if (m_en && !m_ld && m_a == r) return 2'd1;
    else if (w_en && w_a == r)          return 2'd2;
    else                                return 2'd0;
  endfunction

  function automatic logic raw_haz(input logic [4:0] r,
                                   input logic e_en, input logic [4:0] e_a,
                                   input logic m_en, input logic m_ld,
                                   input logic [4:0] m_a);
    return (r != 5'd0) && ((e_en && e_a == r) || (m_en && m_ld && m_a == r));
  endfunction

  // Operand view: live ID fields in IDLE, latched fields while waiting; rt unused by blez/bgtz
  always_comb begin
    eff_op  = (state == S_WAIT) ? op_q  : bus.id_cmp_op;
    eff_rs  = (state == S_WAIT) ? rs_q  : bus.id_rs;
    eff_rt  = (state == S_WAIT) ? rt_q  : bus.id_rt;
    eff_tgt = (state == S_WAIT) ? tgt_q : bus.id_target;
    rt_e    = eff_op[1] ? 5'd0 : eff_rt;
    haz_rs  = raw_haz(eff_rs, bus.ex_wr_en, bus.ex_wr_addr,
                      bus.mem_wr_en, bus.mem_is_load, bus.mem_wr_addr);
    haz_rt  = raw_haz(rt_e, bus.ex_wr_en, bus.ex_wr_addr,
                      bus.mem_wr_en, bus.mem_is_load, bus.mem_wr_addr);
    hazard  = haz_rs || haz_rt;
    fwd_rs  = fwd_sel(eff_rs, bus.mem_wr_en, bus.mem_is_load, bus.mem_wr_addr,
                      bus.wb_wr_en, bus.wb_wr_addr);
    fwd_rt  = fwd_sel(rt_e, bus.mem_wr_en, bus.mem_is_load, bus.mem_wr_addr,
                      bus.wb_wr_en, bus.wb_wr_addr);
    go      = bus.id_valid && bus.id_is_branch && !bus.ext_stall;
  end

  // Next-state and control decode
  always_comb begin
    state_d = state;
    resolve = 1'b0;
    stall_c = 1'b0;
    enter   = 1'b0;
    count   = 1'b0;
    wait_d  = wait_cnt;
    case (state)
      S_IDLE: begin
        if (go) begin
          if (hazard) begin
            stall_c = 1'b1;
            enter   = 1'b1;
            wait_d  = WAIT_W'(1);
            state_d = S_WAIT;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (bus.ext_stall) begin
          stall_c = 1'b1;
        end else begin
          count = 1'b1;
          if (hazard) begin
            stall_c = 1'b1;
            if (wait_cnt != '1) wait_d = wait_cnt + WAIT_W'(1);
          end else begin
            resolve = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      op_q       <= 2'd0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      tgt_q      <= 32'd0;
      rpc_q      <= 32'd0;
      wait_cnt   <= '0;
      err_q      <= 1'b0;
      n_branch_q <= '0;
      n_taken_q  <= '0;
      n_stall_q  <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      if (enter) begin
        op_q  <= bus.id_cmp_op;
        rs_q  <= bus.id_rs;
        rt_q  <= bus.id_rt;
        tgt_q <= bus.id_target;
      end
      if (wait_d > WAIT_W'(MAX_STALL)) err_q <= 1'b1;
      if (resolve) rpc_q <= eff_tgt;
      // Statistics saturate rather than wrap
      if (resolve && n_branch_q != '1) n_branch_q <= n_branch_q + CNT_W'(1);
      if (resolve && bus.cmp_result && n_taken_q != '1) n_taken_q <= n_taken_q + CNT_W'(1);
      if (count && n_stall_q != '1) n_stall_q <= n_stall_q + CNT_W'(1);
    end
  end

  // Decoded outputs are forced idle while reset is held
  assign bus.stall       = reset && stall_c;
  assign bus.cmp_b       = reset && resolve;
  assign bus.cmp_op      = (reset && resolve) ? eff_op : 2'd0;
  assign bus.redirect    = reset && resolve && bus.cmp_result;
  assign bus.redirect_pc = (reset && resolve) ? eff_tgt : rpc_q;
  assign bus.fwd_rs_sel  = reset ? fwd_rs : 2'd0;
  assign bus.fwd_rt_sel  = reset ? fwd_rt : 2'd0;
  assign bus.err         = err_q;
  assign bus.n_branch    = n_branch_q;
  assign bus.n_taken     = n_taken_q;
  assign bus.n_stall     = n_stall_q;

endmodule

// File: tb/tb_branch_sched.sv
// Scoreboarded bench for branch_sched: resolves are popped against queued expectations.
module tb_branch_sched;
  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] pc;
    logic        taken;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  branch_sched_if #(.CNT_W(CNT_W)) bus ();

  branch_sched #(.MAX_STALL(3), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_valid     = 1'b0;
    bus.id_is_branch = 1'b0;
    bus.id_cmp_op    = 2'd0;
    bus.id_rs        = 5'd0;
    bus.id_rt        = 5'd0;
    bus.id_target    = 32'd0;
    bus.ext_stall    = 1'b0;
    bus.ex_wr_en     = 1'b0;
    bus.ex_wr_addr   = 5'd0;
    bus.mem_wr_en    = 1'b0;
    bus.mem_wr_addr  = 5'd0;
    bus.mem_is_load  = 1'b0;
    bus.wb_wr_en     = 1'b0;
    bus.wb_wr_addr   = 5'd0;
    bus.cmp_result   = 1'b0;
  endtask

  task automatic branch(input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] tgt, input logic res);
    bus.id_valid     = 1'b1;
    bus.id_is_branch = 1'b1;
    bus.id_cmp_op    = op;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_target    = tgt;
    bus.cmp_result   = res;
  endtask

  task automatic expect_resolve(input logic [1:0] op, input logic [31:0] pc, input logic taken);
    exp_t e;
    e.op = op; e.pc = pc; e.taken = taken;
    sb.push_back(e);
  endtask

  // Every resolve cycle must match the oldest queued expectation
  always @(negedge clk) begin
    if (bus.cmp_b === 1'b1) begin
      if (sb.size() == 0) begin
        check("resolve_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("redirect",    64'(bus.redirect),    64'(mon_e.taken));
        check("redirect_pc", 64'(bus.redirect_pc), 64'(mon_e.pc));
        check("cmp_op",      64'(bus.cmp_op),      64'(mon_e.op));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a live branch and forwardable producer on the inputs
    idle_inputs();
    reset = 1'b0;
    branch(2'd0, 5'd1, 5'd2, 32'h0000_0050, 1'b1);
    bus.mem_wr_en = 1'b1; bus.mem_wr_addr = 5'd1;
    bus.ex_wr_en  = 1'b1; bus.ex_wr_addr  = 5'd2;
    #2;
    check("rst_stall",    64'(bus.stall),       64'd0);
    check("rst_cmp_b",    64'(bus.cmp_b),       64'd0);
    check("rst_fwd_rs",   64'(bus.fwd_rs_sel),  64'd0);
    check("rst_err",      64'(bus.err),         64'd0);
    check("rst_rpc",      64'(bus.redirect_pc), 64'd0);
    check("rst_n_branch", 64'(bus.n_branch),    64'd0);
    repeat (2) tick();
    idle_inputs();
    reset = 1'b1;
    tick();

    // beq $1,$2 with no producers: same-cycle taken resolve
    branch(2'd0, 5'd1, 5'd2, 32'h0000_0100, 1'b1);
    expect_resolve(2'd0, 32'h0000_0100, 1'b1);
    @(negedge clk);
    check("t1_stall", 64'(bus.stall),      64'd0);
    check("t1_cmp_b", 64'(bus.cmp_b),      64'd1);
    check("t1_fwd",   64'(bus.fwd_rs_sel), 64'd0);
    tick();
    idle_inputs();
    check("t1_n_branch", 64'(bus.n_branch), 64'd1);
    check("t1_n_taken",  64'(bus.n_taken),  64'd1);
    @(negedge clk);
    check("t1_idle_redirect", 64'(bus.redirect),    64'd0);
    check("t1_idle_cmp_b",    64'(bus.cmp_b),       64'd0);
    check("t1_rpc_hold",      64'(bus.redirect_pc), 64'h100);
    tick();

    // addu $3 in EX, bne $3,$0: one stall, then forward from MEM
    branch(2'd1, 5'd3, 5'd0, 32'h0000_0200, 1'b0);
    bus.ex_wr_en = 1'b1; bus.ex_wr_addr = 5'd3;
    expect_resolve(2'd1, 32'h0000_0200, 1'b0);
    @(negedge clk);
    check("t2_stall", 64'(bus.stall), 64'd1);
    check("t2_cmp_b", 64'(bus.cmp_b), 64'd0);
    tick();
    bus.ex_wr_en = 1'b0;
    bus.mem_wr_en = 1'b1; bus.mem_wr_addr = 5'd3; bus.mem_is_load = 1'b0;
    @(negedge clk);
    check("t2_stall_clr", 64'(bus.stall),      64'd0);
    check("t2_cmp_b_res", 64'(bus.cmp_b),      64'd1);
    check("t2_fwd_rs",    64'(bus.fwd_rs_sel), 64'd1);
    tick();
    idle_inputs();
    check("t2_n_stall",  64'(bus.n_stall),  64'd1);
    check("t2_n_branch", 64'(bus.n_branch), 64'd2);
    check("t2_n_taken",  64'(bus.n_taken),  64'd1);

    // lw $4 in EX, beq $4,$5: two stalls, then forward from WB
    branch(2'd0, 5'd4, 5'd5, 32'h0000_0300, 1'b1);
    bus.ex_wr_en = 1'b1; bus.ex_wr_addr = 5'd4;
    expect_resolve(2'd0, 32'h0000_0300, 1'b1);
    @(negedge clk);
    check("t3_stall_ex", 64'(bus.stall), 64'd1);
    tick();
    bus.ex_wr_en = 1'b0;
    bus.mem_wr_en = 1'b1; bus.mem_wr_addr = 5'd4; bus.mem_is_load = 1'b1;
    @(negedge clk);
    check("t3_stall_mem", 64'(bus.stall), 64'd1);
    check("t3_cmp_b_mem", 64'(bus.cmp_b), 64'd0);
    tick();
    bus.mem_wr_en = 1'b0; bus.mem_is_load = 1'b0;
    bus.wb_wr_en = 1'b1; bus.wb_wr_addr = 5'd4;
    @(negedge clk);
    check("t3_stall_clr", 64'(bus.stall),      64'd0);
    check("t3_fwd_rs",    64'(bus.fwd_rs_sel), 64'd2);
    tick();
    idle_inputs();
    check("t3_n_stall",  64'(bus.n_stall),  64'd3);
    check("t3_n_branch", 64'(bus.n_branch), 64'd3);
    check("t3_n_taken",  64'(bus.n_taken),  64'd2);
    check("t3_err",      64'(bus.err),      64'd0);

    // blez $0 with an EX write to $0: register zero never hazards or forwards
    branch(2'd2, 5'd0, 5'd9, 32'h0000_0400, 1'b0);
    bus.ex_wr_en = 1'b1; bus.ex_wr_addr = 5'd0;
    bus.mem_wr_en = 1'b1; bus.mem_wr_addr = 5'd9; bus.mem_is_load = 1'b1;
    expect_resolve(2'd2, 32'h0000_0400, 1'b0);
    @(negedge clk);
    check("t4_stall",  64'(bus.stall),      64'd0);
    check("t4_fwd_rs", 64'(bus.fwd_rs_sel), 64'd0);
    check("t4_cmp_b",  64'(bus.cmp_b),      64'd1);
    tick();
    idle_inputs();
    check("t4_n_branch", 64'(bus.n_branch), 64'd4);

    // Freeze WAIT with ext_stall, then hold the hazard long enough to trip err
    branch(2'd0, 5'd6, 5'd7, 32'h0000_0500, 1'b1);
    bus.ex_wr_en = 1'b1; bus.ex_wr_addr = 5'd6;
    expect_resolve(2'd0, 32'h0000_0500, 1'b1);
    @(negedge clk);
    check("t5_stall_enter", 64'(bus.stall), 64'd1);
    tick();
    bus.ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_frz_cmp_b", 64'(bus.cmp_b), 64'd0);
      check("t5_frz_stall", 64'(bus.stall), 64'd1);
      tick();
      check("t5_frz_n_stall",  64'(bus.n_stall),  64'd3);
      check("t5_frz_n_branch", 64'(bus.n_branch), 64'd4);
    end
    bus.ext_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_haz_stall", 64'(bus.stall), 64'd1);
      tick();
      check("t5_err", 64'(bus.err), (i == 2) ? 64'd1 : 64'd0);
    end
    bus.ex_wr_en = 1'b0;
    @(negedge clk);
    check("t5_res_stall", 64'(bus.stall), 64'd0);
    check("t5_res_cmp_b", 64'(bus.cmp_b), 64'd1);
    tick();
    idle_inputs();
    check("t5_n_stall",  64'(bus.n_stall),  64'd7);
    check("t5_n_branch", 64'(bus.n_branch), 64'd5);
    check("t5_n_taken",  64'(bus.n_taken),  64'd3);
    @(negedge clk);
    check("t5_err_sticky", 64'(bus.err), 64'd1);
    tick();

    // Reset in the middle of WAIT, then the branch is re-presented
    branch(2'd1, 5'd8, 5'd9, 32'h0000_0600, 1'b1);
    bus.ex_wr_en = 1'b1; bus.ex_wr_addr = 5'd8;
    @(negedge clk);
    check("t6_stall_enter", 64'(bus.stall), 64'd1);
    tick();
    reset = 1'b0;
    #1;
    check("t6_rst_stall",    64'(bus.stall),    64'd0);
    check("t6_rst_cmp_b",    64'(bus.cmp_b),    64'd0);
    check("t6_rst_err",      64'(bus.err),      64'd0);
    check("t6_rst_n_branch", 64'(bus.n_branch), 64'd0);
    check("t6_rst_n_stall",  64'(bus.n_stall),  64'd0);
    check("t6_rst_n_taken",  64'(bus.n_taken),  64'd0);
    bus.ex_wr_en = 1'b0;
    tick();
    reset = 1'b1;
    expect_resolve(2'd1, 32'h0000_0600, 1'b1);
    @(negedge clk);
    check("t6_re_stall", 64'(bus.stall), 64'd0);
    check("t6_re_cmp_b", 64'(bus.cmp_b), 64'd1);
    tick();
    idle_inputs();
    check("t6_n_branch", 64'(bus.n_branch), 64'd1);
    check("t6_n_taken",  64'(bus.n_taken),  64'd1);
    check("t6_n_stall",  64'(bus.n_stall),  64'd0);

    repeat (2) tick();
    check("sb_pending", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
